// File: rtl/counter_up_if.sv
// Control/status bundle for counter_up: enable, clear and limit in; count, wrap, laps and done out.
interface counter_up_if #(
    parameter int unsigned N = 4
);
    logic         en;
    logic         clr;
    logic [N-1:0] limit;
    logic [N-1:0] count;
    logic         wrap;
    logic [N-1:0] laps;
    logic         done;

    modport master (
        output en, clr, limit,
        input  count, wrap, laps, done
    );

    modport slave (
        input  en, clr, limit,
        output count, wrap, laps, done
    );
endinterface

// File: rtl/counter_up.sv
// Up counter with programmable terminal value, wrap pulse and saturating lap counter.
// Define COUNTER_UP_SATURATE_EN to stop at the limit (sticky done) instead of wrapping.
module counter_up #(
    parameter int unsigned N = 4
) (
    input  logic          clk,
    input  logic          rst,
    counter_up_if.slave   bus
);
    localparam logic [N-1:0] LAPS_MAX = {N{1'b1}};

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] laps_q, laps_d;
    logic [N-1:0] laps_inc;
    logic         wrap_q, wrap_d;
    logic         done_q, done_d;

    // State register; reset clears everything, including any pending wrap pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            laps_q  <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            laps_q  <= laps_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    // Next-state: clr beats en; wrap defaults low so it only pulses on a terminal cycle
    always_comb begin
        count_d  = count_q;
        laps_d   = laps_q;
        wrap_d   = 1'b0;
        done_d   = done_q;
        laps_inc = (laps_q == LAPS_MAX) ? laps_q : laps_q + N'(1);

        if (bus.clr) begin
            count_d = '0;
            laps_d  = '0;
            done_d  = 1'b0;
        end else if (bus.en) begin
`ifdef COUNTER_UP_SATURATE_EN
            if (!done_q) begin
                if (count_q < bus.limit) begin
                    count_d = count_q + N'(1);
                end else begin
                    count_d = bus.limit;
                    done_d  = 1'b1;
                    wrap_d  = 1'b1;
                    laps_d  = laps_inc;
                end
            end
`else
            // count >= limit also covers a limit lowered below the current count
            if (count_q < bus.limit) begin
                count_d = count_q + N'(1);
            end else begin
                count_d = '0;
                wrap_d  = 1'b1;
                laps_d  = laps_inc;
            end
`endif
        end
    end

    assign bus.count = count_q;
    assign bus.laps  = laps_q;
    assign bus.wrap  = wrap_q;
`ifdef COUNTER_UP_SATURATE_EN
    assign bus.done  = done_q;
`else
    assign bus.done  = 1'b0;
`endif

endmodule

// File: tb/tb_counter_up.sv
// Directed bench for counter_up at N=2; expected values are hand-computed per scenario.
module tb_counter_up;
    localparam int unsigned N = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    counter_up_if #(.N(N)) bus ();

    counter_up #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected sequences
    int seq_cnt  [5] = '{1, 2, 3, 0, 1};
    int seq_wrap [5] = '{0, 0, 0, 1, 0};
    int z_laps   [5] = '{1, 2, 3, 3, 3};
    int sat_cnt  [5] = '{1, 2, 2, 2, 2};
    int sat_done [5] = '{0, 0, 1, 1, 1};
    int sat_wrap [5] = '{0, 0, 1, 0, 0};
    int sat_laps [5] = '{0, 0, 1, 1, 1};

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then sample at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int c, input int w, input int l, input int d);
        check({tag, ".count"}, int'(bus.count), c);
        check({tag, ".wrap"},  int'(bus.wrap),  w);
        check({tag, ".laps"},  int'(bus.laps),  l);
        check({tag, ".done"},  int'(bus.done),  d);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        bus.en    = 1'b0;
        bus.clr   = 1'b0;
        bus.limit = 2'd3;
        step();
        step();
        check_all("reset", 0, 0, 0, 0);
        rst = 1'b1;

`ifdef COUNTER_UP_SATURATE_EN
        bus.limit = 2'd2;
        bus.en    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("sat[%0d]", i), sat_cnt[i], sat_wrap[i], sat_laps[i], sat_done[i]);
        end
        bus.clr = 1'b1;
        step();
        check_all("sat_clr", 0, 0, 0, 0);
        bus.clr = 1'b0;
        step();
        check_all("sat_restart", 1, 0, 0, 0);
`else
        // Full-range count, limit = all ones
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("seq[%0d].count", i), int'(bus.count), seq_cnt[i]);
            check($sformatf("seq[%0d].wrap", i),  int'(bus.wrap),  seq_wrap[i]);
        end
        check("seq.laps", int'(bus.laps), 1);
        check("seq.done", int'(bus.done), 0);

        // Lower the limit below the current count
        step();
        step();
        check("pre_lower.count", int'(bus.count), 3);
        bus.limit = 2'd1;
        step();
        check_all("lowered", 0, 1, 2, 0);

        // Enable low holds, wrap drops
        bus.en = 1'b0;
        step();
        check_all("hold", 0, 0, 2, 0);

        // clr beats en
        bus.limit = 2'd3;
        bus.en    = 1'b1;
        step();
        step();
        check_all("pre_clr", 2, 0, 2, 0);
        bus.clr = 1'b1;
        step();
        check_all("clr_en", 0, 0, 0, 0);
        bus.clr = 1'b0;

        // limit = 0: wrap stays high, laps saturates
        bus.limit = 2'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("zero[%0d]", i), 0, 1, z_laps[i], 0);
        end

        // Async reset between edges discards a pending wrap
        rst = 1'b0;
        #2;
        check_all("rst_wrap", 0, 0, 0, 0);
        rst = 1'b1;
        bus.limit = 2'd3;
        step();
        step();
        check("pre_rst.count", int'(bus.count), 2);
        #1;
        rst = 1'b0;
        #1;
        check_all("rst_mid", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_all("after_rst", 1, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_up.md
COUNTER_UP -- requirements
Module: counter_up

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the bit width of count, limit, and laps.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port en, input, 1 bit: count enable, sampled on rising clk.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of count to 0.
REQ-006 The block SHALL have port limit, input, N bits: terminal value, sampled every cycle.
REQ-007 The block SHALL have port count, output, N bits: current count value, registered.
REQ-008 The block SHALL have port wrap, output, 1 bit: one-cycle registered pulse on terminal transition.
REQ-009 The block SHALL have port laps, output, N bits: number of terminal transitions since reset or clr, registered.
REQ-010 The block SHALL have port done, output, 1 bit: sticky flag, used only in saturate mode (see Configuration).

Function
REQ-011 On a rising clk with clr=1, the block SHALL set count=0, laps=0, wrap=0, and done=0, regardless of en.
REQ-012 clr SHALL take priority over en.
REQ-013 With clr=0 and en=0, count, laps, and done SHALL hold their values, and wrap SHALL be 0 on the next cycle.
REQ-014 With clr=0, en=1, and count < limit, the block SHALL set count <= count+1 and wrap <= 0.
REQ-015 With clr=0, en=1, and count >= limit, the block SHALL take the terminal transition: count <= 0, wrap <= 1, laps <= laps+1.
REQ-016 The terminal transition SHALL also apply when count > limit, i.e. when limit was lowered mid-run.
REQ-017 wrap SHALL be high for exactly one cycle per terminal transition.
REQ-018 wrap SHALL coincide with the first cycle in which count=0 after that transition.
REQ-019 When terminal transitions occur on back-to-back enabled cycles (limit=0), wrap SHALL stay high continuously.
REQ-020 laps SHALL saturate at 2^N-1 and SHALL NOT wrap.
REQ-021 With limit=0 and en=1 held, count SHALL remain 0 and laps SHALL increment every cycle until saturated.
REQ-022 Latency from en sampled high to count change SHALL be one clock.
REQ-023 count SHALL never exceed 2^N-1; with limit=2^N-1, the terminal transition occurs at all-ones.
REQ-024 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-025 While rst=0, count, wrap, laps, and done SHALL be forced to 0 immediately, without waiting for a clk edge.
REQ-026 A reset assertion that does not coincide with a clock edge SHALL take effect within the same cycle.
REQ-027 After rst is released, the first rising clk edge SHALL act per REQ-011 to REQ-015.
REQ-028 Reset mid-count SHALL discard any pending wrap pulse.

Configuration
REQ-029 When macro COUNTER_UP_SATURATE_EN is defined, the block SHALL replace the terminal transition with: count holds at limit, done <= 1, wrap pulses once on entry, and laps increments once.
REQ-030 With COUNTER_UP_SATURATE_EN defined, further en cycles SHALL leave all outputs unchanged; only clr or rst restarts the count.
REQ-031 When COUNTER_UP_SATURATE_EN is not defined, done SHALL be tied to 0 and the wrapping behaviour of REQ-015 SHALL apply.

Verification (N=2 unless noted)
REQ-032 Scenario: rst=0 asserted between clock edges while count=2 -> count=0, laps=0, wrap=0 before the next edge.
REQ-033 Scenario: limit=2'b11, en=1 held for 5 cycles from 0 -> count sequence 1,2,3,0,1; wrap high only while count first shows 0; laps=1.
REQ-034 Scenario: limit=2'b01 with count=3 (after lowering the limit), en=1 -> next count=0, wrap=1, laps incremented.
REQ-035 Scenario: clr=1 and en=1 on the same edge with count=2 and laps=2 -> count=0, laps=0, wrap=0.
REQ-036 Scenario: limit=0, en=1 held for 5 cycles -> count stays 0, wrap high for all 5 cycles, laps saturates at 3.
REQ-037 Scenario (COUNTER_UP_SATURATE_EN defined): limit=2, en=1 held for 5 cycles -> count 1,2,2,2,2; done=1 from the third cycle; single wrap pulse; laps=1.
